// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared mode encoding, BCD type and time limits for the timekeeper
package clock_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_SET_HR  = 2'b01,
      ST_SET_MIN = 2'b10,
      ST_RUN_ALT = 2'b11
   } clk_state_e;

   typedef logic [3:0] bcd_t;

   localparam int HR_MAX  = 23;
   localparam int MIN_MAX = 59;
   localparam int SEC_MAX = 59;

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic is_set(input clk_state_e s);
      return (s == ST_SET_HR) || (s == ST_SET_MIN);
   endfunction

endpackage

// File: rtl/btn_step.sv
// rtl/btn_step.sv - button synchronizer, rising-edge step and hold-to-auto-repeat
module btn_step #(
   parameter int SYNC_STAGES      = 2,
   parameter int REPEAT_DELAY_CYC = 25_000_000,
   parameter int REPEAT_RATE_CYC  = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   input  logic other_held,
   input  logic clear,
   output logic held,
   output logic step
);

   localparam int DW = $clog2(REPEAT_DELAY_CYC);
   localparam int RW = $clog2(REPEAT_RATE_CYC);
   localparam int CW = (DW > RW) ? DW : RW;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   armed_q;
   logic [CW-1:0]          cnt_q;
   logic                   rise;

   assign held = sync_q[SYNC_STAGES-1];
   assign rise = held & ~prev_q;

   // A step needs an arming rise; both-held or a mode change disarms until a fresh rise.
   always_comb begin
      step = 1'b0;
      if (!clear && !other_held && held)
         step = rise || (armed_q && (cnt_q == '0));
   end

   // cnt_q counts down to the next repeat step; 0 while armed means "step now".
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
         prev_q <= held;
         if (clear || other_held || !held) begin
            armed_q <= 1'b0;
            cnt_q   <= '0;
         end else if (rise) begin
            armed_q <= 1'b1;
            cnt_q   <= CW'(REPEAT_DELAY_CYC - 1);
         end else if (armed_q) begin
            if (cnt_q == '0)
               cnt_q <= CW'(REPEAT_RATE_CYC - 1);
            else
               cnt_q <= cnt_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/clock_timekeeper.sv
// rtl/clock_timekeeper.sv - BCD 24-hour time of day with button set modes
module clock_timekeeper
   import clock_pkg::*;
#(
   parameter int SYNC_STAGES      = 2,
   parameter int REPEAT_DELAY_CYC = 25_000_000,
   parameter int REPEAT_RATE_CYC  = 5_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_sec,
   input  logic [1:0] state,
   input  logic       btn_up,
   input  logic       btn_down,
   output bcd_t       hr_tens,
   output bcd_t       hr_ones,
   output bcd_t       min_tens,
   output bcd_t       min_ones,
   output bcd_t       sec_tens,
   output bcd_t       sec_ones,
   output logic       day_pulse,
   output logic       set_active
);

   localparam logic [7:0] HR_MAX_BCD  = to_bcd(HR_MAX);
   localparam logic [7:0] MIN_MAX_BCD = to_bcd(MIN_MAX);
   localparam logic [7:0] SEC_MAX_BCD = to_bcd(SEC_MAX);

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
      if (v == max_v)
         return 8'h00;
      else if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
      if (v == 8'h00)
         return max_v;
      else if (v[3:0] == 4'd0)
         return {v[7:4] - 4'd1, 4'd9};
      else
         return {v[7:4], v[3:0] - 4'd1};
   endfunction

   clk_state_e cur_state;
   clk_state_e prev_state_q;
   logic [7:0] hr_q, min_q, sec_q;
   logic       up_held, down_held, up_step, down_step;
   logic       state_chg, leaving_set;

   assign cur_state   = clk_state_e'(state);
   assign state_chg   = (cur_state != prev_state_q);
   assign leaving_set = is_set(prev_state_q) && !is_set(cur_state);

   btn_step #(
      .SYNC_STAGES      (SYNC_STAGES),
      .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
      .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
   ) u_btn_up (
      .clk        (clk),
      .rst        (rst),
      .btn        (btn_up),
      .other_held (down_held),
      .clear      (state_chg),
      .held       (up_held),
      .step       (up_step)
   );

   btn_step #(
      .SYNC_STAGES      (SYNC_STAGES),
      .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
      .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
   ) u_btn_down (
      .clk        (clk),
      .rst        (rst),
      .btn        (btn_down),
      .other_held (up_held),
      .clear      (state_chg),
      .held       (down_held),
      .step       (down_step)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         hr_q         <= 8'h00;
         min_q        <= 8'h00;
         sec_q        <= 8'h00;
         day_pulse    <= 1'b0;
         set_active   <= 1'b0;
         prev_state_q <= ST_RUN;
      end else begin
         day_pulse    <= 1'b0;
         set_active   <= is_set(cur_state);
         prev_state_q <= cur_state;
         case (cur_state)
            ST_SET_HR: begin
               if (up_step)
                  hr_q <= bcd_inc(hr_q, HR_MAX_BCD);
               else if (down_step)
                  hr_q <= bcd_dec(hr_q, HR_MAX_BCD);
            end
            ST_SET_MIN: begin
               if (up_step)
                  min_q <= bcd_inc(min_q, MIN_MAX_BCD);
               else if (down_step)
                  min_q <= bcd_dec(min_q, MIN_MAX_BCD);
            end
            ST_RUN, ST_RUN_ALT: begin
               // Exiting a set mode restarts the minute; a coincident tick is dropped.
               if (leaving_set) begin
                  sec_q <= 8'h00;
               end else if (tick_sec) begin
                  sec_q <= bcd_inc(sec_q, SEC_MAX_BCD);
                  if (sec_q == SEC_MAX_BCD) begin
                     min_q <= bcd_inc(min_q, MIN_MAX_BCD);
                     if (min_q == MIN_MAX_BCD) begin
                        hr_q <= bcd_inc(hr_q, HR_MAX_BCD);
                        if (hr_q == HR_MAX_BCD)
                           day_pulse <= 1'b1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign hr_tens  = hr_q[7:4];
   assign hr_ones  = hr_q[3:0];
   assign min_tens = min_q[7:4];
   assign min_ones = min_q[3:0];
   assign sec_tens = sec_q[7:4];
   assign sec_ones = sec_q[3:0];

endmodule
